// File: rtl/return_addr_stack_pkg.sv
// Shared definitions for the return address stack: default depth, pointer/count types.
package return_addr_stack_pkg;
  localparam int RAS_DEPTH_DEFAULT = 8;
  localparam int RAS_ADDR_STEP     = 4;

  typedef logic [$clog2(RAS_DEPTH_DEFAULT)-1:0] ras_ptr_t;
  typedef logic [$clog2(RAS_DEPTH_DEFAULT):0]   ras_cnt_t;
endpackage

// File: rtl/return_addr_stack.sv
// Circular return address stack with saturating occupancy count and flop storage.
// Optional macro RAS_RECOVER_EN adds tos/cnt checkpoint outputs and a recovery load port.
module return_addr_stack
  import return_addr_stack_pkg::*;
#(
  parameter int RAS_DEPTH = RAS_DEPTH_DEFAULT,
  parameter int ADDR_W    = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         call_i,
  input  logic                         return_i,
  input  logic [ADDR_W-1:0]            pc_i,
  input  logic                         flush_i,
`ifdef RAS_RECOVER_EN
  output logic [$clog2(RAS_DEPTH)-1:0] ckpt_tos_o,
  output logic [$clog2(RAS_DEPTH):0]   ckpt_cnt_o,
  input  logic                         recover_i,
  input  logic [$clog2(RAS_DEPTH)-1:0] recover_tos_i,
  input  logic [$clog2(RAS_DEPTH):0]   recover_cnt_i,
`endif
  output logic [ADDR_W-1:0]            ret_addr_o,
  output logic                         ret_vld_o
);
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] entry_q [RAS_DEPTH];
  logic [PTR_W-1:0]  tos_q, tos_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we;
  logic [PTR_W-1:0]  wr_idx;
  logic [ADDR_W-1:0] wr_data;

  always_comb begin
    tos_d   = tos_q;
    cnt_d   = cnt_q;
    we      = 1'b0;
    wr_idx  = tos_q;
    wr_data = pc_i + ADDR_W'(RAS_ADDR_STEP);
    if (flush_i) begin
      tos_d = '0;
      cnt_d = '0;
    end
`ifdef RAS_RECOVER_EN
    else if (recover_i) begin
      tos_d = recover_tos_i;
      cnt_d = recover_cnt_i;
    end
`endif
    else if (call_i && return_i) begin
      // Co-routine swap replaces the top in place.
      we = 1'b1;
      if (cnt_q == '0) cnt_d = CNT_W'(1);
    end else if (call_i) begin
      tos_d  = tos_q + PTR_W'(1);
      wr_idx = tos_q + PTR_W'(1);
      we     = 1'b1;
      if (cnt_q != CNT_FULL) cnt_d = cnt_q + CNT_W'(1);
    end else if (return_i && (cnt_q != '0)) begin
      tos_d = tos_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tos_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) entry_q[i] <= '0;
    end else begin
      tos_q <= tos_d;
      cnt_q <= cnt_d;
      if (we) entry_q[wr_idx] <= wr_data;
    end
  end

  assign ret_addr_o = entry_q[tos_q];
  assign ret_vld_o  = (cnt_q != '0);

`ifdef RAS_RECOVER_EN
  assign ckpt_tos_o = tos_q;
  assign ckpt_cnt_o = cnt_q;
`endif
endmodule

// File: tb/tb_return_addr_stack.sv
// Self-checking bench: queue-based reference model compared every cycle, plus literal checks.
module tb_return_addr_stack;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        call_i = 1'b0, return_i = 1'b0, flush_i = 1'b0;
  logic [31:0] pc_i = '0;
  logic [31:0] ret_addr_o;
  logic        ret_vld_o;
`ifdef RAS_RECOVER_EN
  logic [2:0]  ckpt_tos_o;
  logic [3:0]  ckpt_cnt_o;
  logic        recover_i = 1'b0;
  logic [2:0]  recover_tos_i = '0;
  logic [3:0]  recover_cnt_i = '0;
  logic [2:0]  sv_tos;
  logic [3:0]  sv_cnt;
`endif

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;
  logic [31:0] model_q[$];

  return_addr_stack #(.RAS_DEPTH(8), .ADDR_W(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .call_i(call_i), .return_i(return_i),
    .pc_i(pc_i), .flush_i(flush_i),
`ifdef RAS_RECOVER_EN
    .ckpt_tos_o(ckpt_tos_o), .ckpt_cnt_o(ckpt_cnt_o), .recover_i(recover_i),
    .recover_tos_i(recover_tos_i), .recover_cnt_i(recover_cnt_i),
`endif
    .ret_addr_o(ret_addr_o), .ret_vld_o(ret_vld_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end else
      $display("ok   %s = 0x%08h", name, act);
  endtask

  // Model: newest entry at the back, at most 8 live entries.
  task automatic model_update(input bit c, input bit r, input logic [31:0] pc, input bit f);
    logic [31:0] t;
    t = pc + 32'd4;
    if (f) model_q.delete();
    else if (c && r) begin
      if (model_q.size() == 0) model_q.push_back(t);
      else model_q[model_q.size()-1] = t;
    end else if (c) begin
      model_q.push_back(t);
      if (model_q.size() > 8) void'(model_q.pop_front());
    end else if (r && model_q.size() != 0) void'(model_q.pop_back());
  endtask

  task automatic step(input bit c, input bit r, input logic [31:0] pc, input bit f);
    call_i = c; return_i = r; pc_i = pc; flush_i = f;
    @(posedge clk_i);
    model_update(c, r, pc, f);
    #1;
    call_i = 1'b0; return_i = 1'b0; flush_i = 1'b0;
  endtask

  always @(negedge clk_i) begin
    if (chk_en && rst_ni) begin
      total++;
      if (ret_vld_o !== (model_q.size() != 0)) begin
        bad++;
        $display("FAIL model_vld actual=%0b required=%0b t=%0t", ret_vld_o, model_q.size() != 0, $time);
      end
      if (model_q.size() != 0) begin
        total++;
        if (ret_addr_o !== model_q[model_q.size()-1]) begin
          bad++;
          $display("FAIL model_addr actual=0x%08h required=0x%08h t=%0t",
                   ret_addr_o, model_q[model_q.size()-1], $time);
        end
      end
    end
  end

  initial begin
    #12;
    check("reset_addr", ret_addr_o, 32'h0);
    check("reset_vld", {31'b0, ret_vld_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    chk_en = 1'b1;

    step(1, 0, 32'h1000, 0);
    check("call_addr", ret_addr_o, 32'h1004);
    check("call_vld", {31'b0, ret_vld_o}, 32'd1);
    step(0, 1, 32'h1004, 0);
    check("pop_vld", {31'b0, ret_vld_o}, 32'd0);

    for (int k = 1; k <= 9; k++) step(1, 0, 32'h100 * k, 0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("ovf_pop%0d", i), ret_addr_o, 32'h904 - 32'h100 * i);
      step(0, 1, 32'h0, 0);
    end
    check("ovf_empty_vld", {31'b0, ret_vld_o}, 32'd0);
    step(0, 1, 32'h0, 0);
    check("underflow_vld", {31'b0, ret_vld_o}, 32'd0);
    step(1, 0, 32'h500, 0);
    check("after_underflow", ret_addr_o, 32'h504);
    step(0, 1, 32'h0, 0);

    step(1, 0, 32'h2000, 0);
    check("swap_pre", ret_addr_o, 32'h2004);
    step(1, 1, 32'h3000, 0);
    check("swap_addr", ret_addr_o, 32'h3004);
    step(0, 1, 32'h0, 0);
    check("swap_cnt1", {31'b0, ret_vld_o}, 32'd0);

    step(1, 0, 32'h10, 0);
    step(1, 0, 32'h20, 0);
    step(1, 0, 32'h30, 0);
    step(1, 0, 32'h40, 1);
    check("flush_vld", {31'b0, ret_vld_o}, 32'd0);
    step(1, 0, 32'h40, 0);
    check("post_flush", ret_addr_o, 32'h44);

    step(1, 0, 32'hFFFF_FFFC, 0);
    check("wrap_addr", ret_addr_o, 32'h0);
    check("wrap_vld", {31'b0, ret_vld_o}, 32'd1);

`ifdef RAS_RECOVER_EN
    step(0, 0, 32'h0, 1);
    step(1, 0, 32'hA00, 0);
    step(1, 0, 32'hB00, 0);
    sv_tos = ckpt_tos_o;
    sv_cnt = ckpt_cnt_o;
    check("ckpt_cnt", {28'b0, sv_cnt}, 32'd2);
    step(1, 0, 32'hC00, 0);
    step(1, 0, 32'hD00, 0);
    recover_i = 1'b1; recover_tos_i = sv_tos; recover_cnt_i = sv_cnt;
    @(posedge clk_i);
    void'(model_q.pop_back());
    void'(model_q.pop_back());
    #1 recover_i = 1'b0;
    check("recover_addr", ret_addr_o, 32'hB04);
    check("recover_cnt", {28'b0, ckpt_cnt_o}, 32'd2);
    check("recover_tos", {29'b0, ckpt_tos_o}, {29'b0, sv_tos});
`endif

    // Mixed directed vectors exercising all operation types against the model.
    for (int i = 0; i < 40; i++) begin
      case (i % 7)
        0, 1, 3: step(1, 0, 32'h8000 + 32'h10 * i, 0);
        2, 4:    step(0, 1, 32'h0, 0);
        5:       step(1, 1, 32'h9000 + 32'h10 * i, 0);
        default: step(0, 0, 32'h0, (i == 20));
      endcase
    end

    // Reset during a pending push discards it.
    step(1, 0, 32'h7000, 0);
    call_i = 1'b1; pc_i = 32'h7100;
    #2 rst_ni = 1'b0;
    model_q.delete();
    #1;
    check("mid_rst_addr", ret_addr_o, 32'h0);
    check("mid_rst_vld", {31'b0, ret_vld_o}, 32'd0);
    @(posedge clk_i);
    #1 call_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    check("post_rst_vld", {31'b0, ret_vld_o}, 32'd0);
    check("post_rst_addr", ret_addr_o, 32'h0);
    step(0, 1, 32'h0, 0);
    step(1, 0, 32'h1230, 0);
    check("post_rst_call", ret_addr_o, 32'h1234);

    @(negedge clk_i);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/return_addr_stack.md
RETURN_ADDR_STACK -- requirements
Module: return_addr_stack

Interface
REQ-001 The block SHALL expose parameter RAS_DEPTH, default 8, number of stack entries (power of two, >= 2).
REQ-002 The block SHALL expose parameter ADDR_W, default 32, return address width.
REQ-003 The block SHALL have port clk_i, input, 1, the single clock; all state SHALL be on its rising edge.
REQ-004 The block SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port call_i, input, 1, push request, already qualified with fetch-valid.
REQ-006 The block SHALL have port return_i, input, 1, pop request, already qualified with fetch-valid.
REQ-007 The block SHALL have port pc_i, input, ADDR_W, PC of the call/return instruction.
REQ-008 The block SHALL have port flush_i, input, 1, empty the stack.
REQ-009 The block SHALL have port ret_addr_o, output, ADDR_W, predicted return target (current top entry).
REQ-010 The block SHALL have port ret_vld_o, output, 1, high when ret_addr_o is a live entry.

Function
REQ-011 The block SHALL hold RAS_DEPTH entries of ADDR_W bits, a top-of-stack pointer tos, and an occupancy count cnt in range 0..RAS_DEPTH.
REQ-012 ret_addr_o SHALL equal entry[tos] from registers, with no input bypass; a push SHALL become visible on ret_addr_o one cycle later.
REQ-013 ret_vld_o SHALL be (cnt != 0).
REQ-014 Push only (call_i=1, return_i=0): tos <= tos+1 mod RAS_DEPTH, entry[tos+1] <= pc_i+4, cnt <= min(cnt+1, RAS_DEPTH).
REQ-015 Push when full SHALL overwrite the oldest entry by pointer wrap-around; cnt SHALL stay at RAS_DEPTH.
REQ-016 Pop only (return_i=1, call_i=0) with cnt>0: tos <= tos-1 mod RAS_DEPTH, cnt <= cnt-1; entry contents are unchanged.
REQ-017 Pop when cnt=0 SHALL leave tos, cnt and entries unchanged.
REQ-018 Simultaneous call_i and return_i (co-routine swap): entry[tos] <= pc_i+4, tos unchanged, cnt <= max(cnt,1).
REQ-019 The pc_i+4 addition SHALL be modulo 2^ADDR_W; carry out is discarded.
REQ-020 flush_i SHALL have priority over call_i/return_i in the same cycle: tos <= 0, cnt <= 0; entries are not cleared.

Reset
REQ-021 On rst_ni low, tos, cnt and all entries SHALL clear to 0 asynchronously; ret_addr_o=0 and ret_vld_o=0 during and after reset until the first push.
REQ-022 Reset asserted mid-operation SHALL discard all pending pushes and pops; no partial update SHALL survive.

Configuration
REQ-023 Macro RAS_RECOVER_EN SHALL, when defined, add ports ckpt_tos_o (log2 RAS_DEPTH), ckpt_cnt_o (log2 RAS_DEPTH +1), recover_i (1), recover_tos_i, and recover_cnt_i.
REQ-024 With RAS_RECOVER_EN, ckpt_tos_o/ckpt_cnt_o SHALL show the current registered tos/cnt, and recover_i SHALL load tos/cnt from recover_*_i next cycle.
REQ-025 With RAS_RECOVER_EN, priority SHALL be flush_i > recover_i > call_i/return_i.
REQ-026 Without RAS_RECOVER_EN, these ports and their logic SHALL be absent, and behaviour SHALL match REQ-011..REQ-022 exactly.

Structure
REQ-027 The shared core package SHALL hold RAS_DEPTH_DEFAULT and typedefs ras_ptr_t and ras_cnt_t.
REQ-028 No sub-module SHALL be used; storage is a flop array inside return_addr_stack, with no SRAM macro.

Verification
REQ-029 The bench SHALL cover: reset; call pc=0x1000; next cycle ret_addr_o=0x1004, ret_vld_o=1; return pops -> ret_vld_o=0.
REQ-030 The bench SHALL cover overflow: 9 calls, pc=0x100*k for k=1..9, depth 8; then 8 returns yield 0x904..0x204 in order, and a 9th return leaves ret_vld_o=0 with state unchanged.
REQ-031 The bench SHALL cover the swap: stack holds 0x2004; call_i and return_i together with pc=0x3000 -> ret_addr_o=0x3004, cnt unchanged at 1.
REQ-032 The bench SHALL cover flush priority: flush_i with call_i on a 3-deep stack -> cnt=0, ret_vld_o=0 next cycle.
REQ-033 The bench SHALL cover wrap: call pc=0xFFFF_FFFC -> ret_addr_o=0x0000_0000.
REQ-034 With RAS_RECOVER_EN, the bench SHALL cover recovery: checkpoint at cnt=2, then 2 calls, then recover_i with the saved values -> top entry and cnt match the checkpoint.
